// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back cache controller: one CPU requester, one variable-latency memory port.
// Handshakes: cpu_req is held until the one-cycle cpu_ack; mem_req holds until the one-cycle mem_ack.
module wb_cache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 11,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [1:0]        dbg_state
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                retry_q, retry_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;
  logic [LINES-1:0]    valid_q, valid_d, dirty_q, dirty_d;

  logic [DATA_W-1:0]   data_mem [LINES];
  logic [TAG_W-1:0]    tag_mem  [LINES];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [DATA_W-1:0]   line_data;
  logic [TAG_W-1:0]    line_tag;
  logic                hit, victim_dirty, mem_done;
  logic                data_we, tag_we;
  logic [DATA_W-1:0]   data_wval;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign idx          = addr_q[INDEX_W-1:0];
  assign tag          = addr_q[ADDR_W-1:INDEX_W];
  assign line_data    = data_mem[idx];
  assign line_tag     = tag_mem[idx];
  assign hit          = valid_q[idx] && (line_tag == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign mem_done     = mem_req_q && mem_ack;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    retry_d     = retry_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    wb_d        = wb_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    data_wval   = wdata_q;

    case (state_q)
      S_IDLE: begin
        // cpu_ack_q blocks re-acceptance of a request the CPU has not yet dropped
        if (cpu_req && !cpu_ack_q) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          retry_d = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          cpu_ack_d = 1'b1;
          if (we_q) begin
            data_we      = 1'b1;
            dirty_d[idx] = 1'b1;
          end else begin
            cpu_rdata_d = line_data;
          end
          if (!retry_q) hit_d = sat_inc(hit_q);
          state_d = S_IDLE;
        end else begin
          if (!retry_q) miss_d = sat_inc(miss_q);
          if (victim_dirty) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {line_tag, idx};
            mem_wdata_d = line_data;
            state_d     = S_WRITEBACK;
          end else if (we_q) begin
            // write miss over a clean line: install without fetching
            data_we      = 1'b1;
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b1;
            cpu_ack_d    = 1'b1;
            state_d      = S_IDLE;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_done) begin
          mem_req_d    = 1'b0;
          dirty_d[idx] = 1'b0;
          wb_d         = sat_inc(wb_q);
          retry_d      = 1'b1;
          state_d      = S_COMPARE;
        end
      end
      S_ALLOCATE: begin
        if (mem_done) begin
          mem_req_d    = 1'b0;
          data_we      = 1'b1;
          data_wval    = mem_rdata;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          retry_d      = 1'b1;
          state_d      = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      retry_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      wb_q        <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      retry_q     <= retry_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      wb_q        <= wb_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Data and tag storage carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_mem[idx] <= data_wval;
    if (!rst && tag_we)  tag_mem[idx]  <= tag;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign wb_cnt    = wb_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: default-parameter instance checked against a reference cache model,
// plus a narrow instance (12-bit addr, 32-bit data, 16 lines, 4-bit counters) run directed.
module tb_wb_cache_ctrl;
  localparam int LAT_A = 3;
  localparam int LAT_B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A (defaults) ----------------
  logic        a_cpu_req = 1'b0, a_cpu_we = 1'b0;
  logic [15:0] a_cpu_addr = '0, a_cpu_wdata = '0, a_cpu_rdata;
  logic        a_cpu_ack, a_mem_req, a_mem_we;
  logic [15:0] a_mem_addr, a_mem_wdata;
  logic [15:0] a_mem_rdata = '0;
  logic        a_mem_ack = 1'b0;
  logic [15:0] a_hit, a_miss, a_wb;
  logic [1:0]  a_state;

  wb_cache_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
    .hit_cnt(a_hit), .miss_cnt(a_miss), .wb_cnt(a_wb), .dbg_state(a_state)
  );

  // ---------------- instance B (reparametrised) ----------------
  logic        b_cpu_req = 1'b0, b_cpu_we = 1'b0;
  logic [11:0] b_cpu_addr = '0;
  logic [31:0] b_cpu_wdata = '0, b_cpu_rdata;
  logic        b_cpu_ack, b_mem_req, b_mem_we;
  logic [11:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [31:0] b_mem_rdata = '0;
  logic        b_mem_ack = 1'b0;
  logic [3:0]  b_hit, b_miss, b_wb;
  logic [1:0]  b_state;

  wb_cache_ctrl #(.ADDR_W(12), .DATA_W(32), .INDEX_W(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .hit_cnt(b_hit), .miss_cnt(b_miss), .wb_cnt(b_wb), .dbg_state(b_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory models ----------------
  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return a + 16'd1;
  endfunction

  logic [15:0] mem_a [logic [15:0]];
  int a_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      a_mem_ack = 1'b0;
      a_cnt = 0;
    end else if (a_mem_ack) begin
      a_mem_ack = 1'b0;
      a_cnt = 0;
    end else if (a_mem_req) begin
      a_cnt++;
      if (a_cnt >= LAT_A) begin
        a_mem_ack = 1'b1;
        if (a_mem_we) mem_a[a_mem_addr] = a_mem_wdata;
        else a_mem_rdata = mem_a.exists(a_mem_addr) ? mem_a[a_mem_addr] : mem_init(a_mem_addr);
      end
    end else begin
      a_cnt = 0;
    end
  end

  int b_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      b_mem_ack = 1'b0;
      b_cnt = 0;
    end else if (b_mem_ack) begin
      b_mem_ack = 1'b0;
      b_cnt = 0;
    end else if (b_mem_req) begin
      b_cnt++;
      if (b_cnt >= LAT_B) begin
        b_mem_ack = 1'b1;
        b_mem_rdata = 32'hC0DE_0000 | {20'h0, b_mem_addr};
      end
    end else begin
      b_cnt = 0;
    end
  end

  // ---------------- reference model + scoreboard (instance A) ----------------
  bit          m_valid [2048];
  bit          m_dirty [2048];
  logic [4:0]  m_tag   [2048];
  logic [15:0] m_data  [2048];
  logic [15:0] ref_mem [logic [15:0]];
  int          m_hit, m_miss, m_wb;
  logic [32:0] mem_exp_q[$];
  logic [15:0] rd_exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit = 0; m_miss = 0; m_wb = 0;
    mem_exp_q.delete();
    rd_exp_q.delete();
  endtask

  task automatic model_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              output int lat);
    int idx;
    logic [4:0]  tg;
    logic [15:0] vaddr;
    idx = int'(addr[10:0]);
    tg  = addr[15:11];
    lat = 2;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      m_hit++;
      if (we) begin
        m_data[idx] = wdata;
        m_dirty[idx] = 1'b1;
      end else begin
        rd_exp_q.push_back(m_data[idx]);
      end
    end else begin
      m_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        vaddr = {m_tag[idx], addr[10:0]};
        mem_exp_q.push_back({1'b1, vaddr, m_data[idx]});
        ref_mem[vaddr] = m_data[idx];
        m_wb++;
        lat += LAT_A + 1;
      end
      m_tag[idx] = tg;
      m_valid[idx] = 1'b1;
      if (we) begin
        m_data[idx] = wdata;
        m_dirty[idx] = 1'b1;
      end else begin
        mem_exp_q.push_back({1'b0, addr, 16'h0});
        m_data[idx] = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
        m_dirty[idx] = 1'b0;
        lat += LAT_A + 1;
        rd_exp_q.push_back(m_data[idx]);
      end
    end
  endtask

  // memory-port monitor A: order/contents of transactions and stability while pending
  logic        a_prev_req = 1'b0;
  logic [32:0] a_op, a_cur;
  always @(negedge clk) begin
    if (a_mem_req && !a_prev_req) begin
      if (mem_exp_q.size() == 0) begin
        check_eq("a_mem_unexpected", a_mem_req, 0);
      end else begin
        a_op = mem_exp_q.pop_front();
        check_eq("a_mem_we", a_mem_we, a_op[32]);
        check_eq("a_mem_addr", a_mem_addr, a_op[31:16]);
        if (a_op[32]) check_eq("a_mem_wdata", a_mem_wdata, a_op[15:0]);
      end
      a_cur = {a_mem_we, a_mem_addr, a_mem_wdata};
    end else if (a_mem_req && a_prev_req) begin
      check_eq("a_mem_stable", {a_mem_we, a_mem_addr, a_mem_wdata}, a_cur);
    end
    a_prev_req = a_mem_req;
  end

  logic [44:0] b_exp_q[$];
  logic [44:0] b_op;
  logic        b_prev_req = 1'b0;
  always @(negedge clk) begin
    if (b_mem_req && !b_prev_req) begin
      if (b_exp_q.size() == 0) begin
        check_eq("b_mem_unexpected", b_mem_req, 0);
      end else begin
        b_op = b_exp_q.pop_front();
        check_eq("b_mem_we", b_mem_we, b_op[44]);
        check_eq("b_mem_addr", b_mem_addr, b_op[43:32]);
        if (b_op[44]) check_eq("b_mem_wdata", b_mem_wdata, b_op[31:0]);
      end
    end
    b_prev_req = b_mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic a_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int lat_exp, cyc;
    logic [15:0] rexp;
    model_access(we, addr, wdata, lat_exp);
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!a_cpu_ack && cyc < 200);
    a_cpu_req = 1'b0;
    check_eq("a_ack_seen", a_cpu_ack, 1);
    check_eq("a_latency", cyc, lat_exp);
    if (!we) begin
      rexp = rd_exp_q.pop_front();
      check_eq("a_rdata", a_cpu_rdata, rexp);
    end
    check_eq("a_hit_cnt", a_hit, m_hit);
    check_eq("a_miss_cnt", a_miss, m_miss);
    check_eq("a_wb_cnt", a_wb, m_wb);
    check_eq("a_mem_ops_left", mem_exp_q.size(), 0);
    @(negedge clk);
    check_eq("a_ack_pulse", a_cpu_ack, 0);
  endtask

  task automatic a_reset_mid(input logic [15:0] addr);
    int lat_exp, cyc, acks;
    model_access(1'b0, addr, 16'h0, lat_exp);
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = addr;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!a_mem_req && cyc < 50);
    check_eq("a_rm_fill_started", a_mem_req, 1);
    rst = 1'b1;
    a_cpu_req = 1'b0;
    @(negedge clk);
    check_eq("a_rm_mem_req", a_mem_req, 0);
    check_eq("a_rm_ack", a_cpu_ack, 0);
    check_eq("a_rm_counters", {a_hit, a_miss, a_wb}, 0);
    check_eq("a_rm_state", a_state, 0);
    rst = 1'b0;
    model_reset();
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_cpu_ack || a_mem_req) acks++;
    end
    check_eq("a_rm_quiet", acks, 0);
  endtask

  task automatic b_access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rexp, output int cyc);
    @(negedge clk);
    b_cpu_req = 1'b1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!b_cpu_ack && cyc < 200);
    b_cpu_req = 1'b0;
    check_eq("b_ack_seen", b_cpu_ack, 1);
    if (!we) check_eq("b_rdata", b_cpu_rdata, rexp);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [15:0] ra;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("a_rst_outputs", {a_cpu_ack, a_cpu_rdata, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata}, 0);
    check_eq("a_rst_counters", {a_hit, a_miss, a_wb}, 0);
    check_eq("a_rst_state", a_state, 0);
    check_eq("b_rst_outputs", {b_cpu_ack, b_mem_req, b_mem_we, b_mem_addr, b_hit, b_miss, b_wb}, 0);

    // read miss fill, write hit, dirty-victim write miss, dirty-victim read miss
    a_access(1'b0, 16'h8005, 16'h0);
    a_access(1'b1, 16'h8005, 16'hBEEF);
    a_access(1'b1, 16'h0005, 16'h1234);
    a_access(1'b0, 16'h7805, 16'h0);
    a_access(1'b0, 16'h7805, 16'h0);

    a_reset_mid(16'h1234);
    a_access(1'b0, 16'h1234, 16'h0);
    a_access(1'b0, 16'h7805, 16'h0);

    // random traffic over a few indices and tags to force conflicts
    for (int i = 0; i < 60; i++) begin
      ra = {5'($urandom_range(0, 3)), 11'($urandom_range(0, 3))};
      a_access(1'($urandom_range(0, 1)), ra, 16'($urandom));
    end

    // narrow instance: tag/index split, 32-bit data, counter saturation
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_exp_q.push_back({1'b0, 12'h805, 32'h0});
    b_access(1'b0, 12'h805, 32'h0, 32'hC0DE_0805, cyc);
    check_eq("b_fill_latency", cyc, 2 + LAT_B + 1);
    check_eq("b_fill_miss", b_miss, 1);
    for (int i = 0; i < 20; i++) b_access(1'b0, 12'h805, 32'h0, 32'hC0DE_0805, cyc);
    check_eq("b_hit_sat", b_hit, 4'hF);
    check_eq("b_miss_after_hits", b_miss, 1);
    b_access(1'b1, 12'h035, 32'h1234_5678, 32'h0, cyc);
    check_eq("b_wmiss_latency", cyc, 2);
    check_eq("b_wmiss_counts", {b_hit, b_miss, b_wb}, {4'hF, 4'd2, 4'd0});
    b_exp_q.push_back({1'b1, 12'h035, 32'h1234_5678});
    b_exp_q.push_back({1'b0, 12'h805, 32'h0});
    b_access(1'b0, 12'h805, 32'h0, 32'hC0DE_0805, cyc);
    check_eq("b_dirty_latency", cyc, 2 + 2 * (LAT_B + 1));
    check_eq("b_dirty_counts", {b_hit, b_miss, b_wb}, {4'hF, 4'd3, 4'd1});
    check_eq("b_mem_ops_left", b_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_cache_ctrl.md
# wb_cache_ctrl

Parametrised direct-mapped write-back cache controller between a single CPU-side requester and a variable-latency main-memory port. It generalises the fixed 16-bit/2048-line cache model into configurable address, data and index widths. It adds a real request/acknowledge handshake on both sides, write-back of dirty victims and a no-fetch write-allocate policy. Hit/miss/write-back statistics counters are included for performance bring-up.

## Interface
- ADDR_W, 16, word address width; tag width TAG_W = ADDR_W − INDEX_W
- DATA_W, 16, data word width; one word per line
- INDEX_W, 11, line index width; 2^INDEX_W lines
- CNT_W, 16, statistics counter width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  request valid, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read (same sense as r_w_enable)
- cpu_addr  in  ADDR_W  word address, stable while cpu_req
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid only while cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory transaction valid
- mem_we  out  1  1 = write-back, 0 = line fetch
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  fetch data, sampled with mem_ack
- mem_ack  in  1  memory completion, one cycle
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W each  statistics

## Operation
- Line store: data[DATA_W], tag[TAG_W], valid, dirty per line. index = cpu_addr[INDEX_W−1:0], tag = cpu_addr[ADDR_W−1:INDEX_W].
- Valid/dirty arrays are flops cleared by rst; data and tag arrays are not reset.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: if cpu_req=1 and cpu_ack=0, latch addr/we/wdata and go to COMPARE; clear retry flag.
- COMPARE, hit (valid && tag match):
  - read: cpu_rdata = line data, pulse cpu_ack, go to IDLE
  - write: update data, dirty=1, pulse cpu_ack, go to IDLE
  - hit_cnt++ only if retry flag = 0
- COMPARE, miss: miss_cnt++ (first visit only). Then:
  - victim valid && dirty: go to WRITEBACK
  - write with clean/invalid victim: install tag, data, valid=1, dirty=1, pulse cpu_ack, go to IDLE; no fetch
  - read with clean/invalid victim: go to ALLOCATE
- WRITEBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index}, mem_wdata = victim data. On mem_ack: dirty=0, wb_cnt++, set retry, go to COMPARE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr = latched addr. On mem_ack: data = mem_rdata, tag = latched tag, valid=1, dirty=0, set retry, go to COMPARE.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: cpu_ack=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all counters 0, state IDLE.
- All outputs are registered.
- Hit, or write miss to a clean line: request sampled at edge E0, COMPARE at E1, cpu_ack high in cycle E1–E2. Latency 2 cycles.
- Read miss, clean victim: mem_req rises after E1. With mem_ack at edge Em, COMPARE runs at Em+1 and cpu_ack is high after Em+1.
- Dirty victim: the WRITEBACK phase precedes the above, adding memory latency plus 1 cycle.
- mem_req, mem_addr, mem_wdata and mem_we stay stable from assertion until mem_ack is sampled. mem_req drops the edge mem_ack is seen; no back-to-back memory requests without an intervening COMPARE.
- mem_ack while mem_req=0 is ignored.
- cpu_req changes while busy are ignored; the latched request completes.
- The CPU must drop cpu_req in its ack cycle. IDLE never accepts while cpu_ack=1, so the minimum request spacing is 3 cycles.
- rst mid-transaction: next state IDLE, mem_req=0 the following cycle, in-flight memory op abandoned, no cpu_ack, valid/dirty cleared.
- The memory model must tolerate abandoned transactions.
- Same-index back-to-back requests are serialised; there are no hazards.

## Test plan
- Defaults. After rst: read 0x8005. Expect miss, mem_req read at addr 0x8005; mem returns 0x8006 after 3 cycles. Expect cpu_rdata=0x8006, miss_cnt=1, line 5 tag=0x10, V=1, D=0.
- Write hit: write 0x8005 ← 0xBEEF after the fill above. Expect cpu_ack 2 cycles after accept, no mem_req, line 5 D=1, hit_cnt=1.
- Dirty-victim write miss: write 0x0005 ← 0x1234. Expect mem write addr 0x8005 data 0xBEEF, then install with no fetch. Expect line 5 tag=0x00, data 0x1234, D=1, wb_cnt=1, miss_cnt=2, hit_cnt=1.
- Dirty-victim read miss: read 0x7805 with line 5 dirty. Expect write-back to 0x0005 (0x1234), then fetch from 0x7805, then ack. wb_cnt +1, miss_cnt +1, hit_cnt unchanged.
- Reset mid-fill: assert rst while ALLOCATE waits on mem_ack. Expect mem_req=0 next cycle, no cpu_ack, counters 0. A subsequent read of the same address misses again.
- Saturation and reparametrisation (CNT_W=4): issue 20 hits and expect hit_cnt=0xF. Repeat the first scenario with ADDR_W=12, DATA_W=32, INDEX_W=4, and expect the tag/index split and data to match.
